// File: rtl/palette_lut_if.sv
// palette_lut_if: pixel lookup, palette write and colour-cycling signals of palette_lut
interface palette_lut_if #(
  parameter int IDX_W = 3,
  parameter int COLOR_W = 6
);
  logic [IDX_W-1:0] color_index;
  logic blank;
  logic frame_tick;
  logic cycle_en;
  logic wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [COLOR_W-1:0] wr_data;
  logic [COLOR_W-1:0] rrggbb;
  logic [IDX_W-1:0] cyc_offset;
  modport master (
    output color_index, blank, frame_tick, cycle_en, wr_en, wr_addr, wr_data,
    input rrggbb, cyc_offset
  );
  modport slave (
    input color_index, blank, frame_tick, cycle_en, wr_en, wr_addr, wr_data,
    output rrggbb, cyc_offset
  );
endinterface

// File: rtl/palette_lut.sv
// palette_lut: writable colour-cycling palette mapping a pixel index to a registered RRGGBB word
module palette_lut #(
  parameter int IDX_W = 3,
  parameter int COLOR_W = 6,
  parameter int CYC_LO = 1,
  parameter int CYC_HI = 6,
  parameter int CYCLE_PERIOD = 4
) (
  input logic clk,
  input logic reset,
  palette_lut_if.slave bus
);
  localparam int DEPTH = 2 ** IDX_W;
  localparam int N = CYC_HI - CYC_LO + 1;
  localparam int DIV_W = CYCLE_PERIOD > 1 ? $clog2(CYCLE_PERIOD) : 1;
  localparam logic [47:0] DEFAULTS = {6'b111000, 6'b110110, 6'b101101, 6'b111000,
                                      6'b110011, 6'b011111, 6'b001011, 6'b000000};
  localparam logic [IDX_W:0] LO = (IDX_W + 1)'(CYC_LO);
  localparam logic [IDX_W:0] HI = (IDX_W + 1)'(CYC_HI);
  localparam logic [IDX_W:0] NN = (IDX_W + 1)'(N);
  localparam logic [IDX_W-1:0] OFF_LAST = IDX_W'(N - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CYCLE_PERIOD - 1);
  logic [COLOR_W-1:0] pal [DEPTH];
  logic [DIV_W-1:0] div;
  logic [IDX_W:0] idx, sum;
  logic [IDX_W-1:0] eff;
  function automatic logic [COLOR_W-1:0] dflt(int i);
    logic [COLOR_W+5:0] w;
    w = {DEFAULTS[47-6*(i%8) -: 6], {COLOR_W{1'b0}}};
    return i < 8 ? w[COLOR_W+5 -: COLOR_W] : '0;
  endfunction
  always_comb begin
    idx = {1'b0, bus.color_index};
    sum = idx - LO + {1'b0, bus.cyc_offset};
    eff = (idx >= LO && idx <= HI) ? IDX_W'((sum >= NN ? sum - NN : sum) + LO) : bus.color_index;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) pal[i] <= dflt(i);
    end else if (bus.wr_en) begin
      pal[bus.wr_addr] <= bus.wr_data;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rrggbb <= '0;
      bus.cyc_offset <= '0;
      div <= '0;
    end else begin
      bus.rrggbb <= bus.blank ? '0 : pal[eff];
      if (!bus.cycle_en) begin
        div <= '0;
        bus.cyc_offset <= '0;
      end else if (bus.frame_tick) begin
        div <= div == DIV_LAST ? '0 : div + 1'b1;
        if (div == DIV_LAST) bus.cyc_offset <= bus.cyc_offset == OFF_LAST ? '0 : bus.cyc_offset + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_palette_lut.sv
// tb_palette_lut: scoreboard bench for palette_lut against an integer reference model
module tb_palette_lut;
  localparam int P = 4;
  localparam int LO = 1;
  localparam int HI = 6;
  localparam int N = HI - LO + 1;
  localparam logic [5:0] DEF [8] = '{6'b111000, 6'b110110, 6'b101101, 6'b111000,
                                     6'b110011, 6'b011111, 6'b001011, 6'b000000};
  typedef struct {
    int cyc;
    logic [5:0] rgb;
    logic [2:0] off;
  } exp_t;
  logic clk = 1'b0;
  logic reset;
  exp_t q[$];
  int cyc_cnt = 0;
  int errors = 0;
  int checks = 0;
  int pal_m [8];
  int off_m = 0;
  int div_m = 0;
  always #5 clk = ~clk;
  palette_lut_if #(.IDX_W(3), .COLOR_W(6)) bus ();
  palette_lut #(.IDX_W(3), .COLOR_W(6), .CYC_LO(LO), .CYC_HI(HI), .CYCLE_PERIOD(P)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (bus.rrggbb !== e.rgb || bus.cyc_offset !== e.off) begin
        errors++;
        $display("FAIL scoreboard cycle %0d: got rrggbb=%b cyc_offset=%0d, expected rrggbb=%b cyc_offset=%0d",
                 e.cyc, bus.rrggbb, bus.cyc_offset, e.rgb, e.off);
      end
    end
  end
  task automatic step(input logic rst, input logic [2:0] idx, input logic blk, input logic tick,
                      input logic cen, input logic we, input logic [2:0] wa, input logic [5:0] wd);
    exp_t e;
    int eff;
    reset = rst;
    bus.color_index = idx;
    bus.blank = blk;
    bus.frame_tick = tick;
    bus.cycle_en = cen;
    bus.wr_en = we;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    eff = (idx >= LO && idx <= HI) ? LO + (int'(idx) - LO + off_m) % N : int'(idx);
    e.cyc = cyc_cnt + 1;
    e.rgb = (rst || blk) ? 6'd0 : 6'(pal_m[eff]);
    if (rst) begin
      off_m = 0;
      div_m = 0;
      for (int i = 0; i < 8; i++) pal_m[i] = DEF[i];
    end else begin
      if (we) pal_m[wa] = wd;
      if (!cen) begin
        off_m = 0;
        div_m = 0;
      end else if (tick) begin
        div_m++;
        if (div_m == P) begin
          div_m = 0;
          off_m = (off_m + 1) % N;
        end
      end
    end
    e.off = 3'(off_m);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0, 3'($urandom), 0, 1, 1, 0, 0, 0);
  endtask
  initial begin
    for (int i = 0; i < 8; i++) pal_m[i] = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_rgb", bus.rrggbb, 6'd0);
    chk("reset_off", 6'(bus.cyc_offset), 6'd0);
    for (int i = 0; i < 8; i++) begin
      step(0, 3'(i), 0, 0, 0, 0, 0, 0);
      chk($sformatf("sweep%0d", i), bus.rrggbb, DEF[i]);
    end
    step(0, 1, 1, 0, 0, 0, 0, 0);
    chk("blank", bus.rrggbb, 6'b000000);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("unblank", bus.rrggbb, 6'b110110);
    step(0, 3, 0, 0, 0, 1, 3, 6'b010101);
    chk("write_old", bus.rrggbb, 6'b111000);
    step(0, 3, 0, 0, 0, 0, 0, 0);
    chk("write_new", bus.rrggbb, 6'b010101);
    ticks(4);
    chk("off_after4", 6'(bus.cyc_offset), 6'd1);
    step(0, 1, 0, 0, 1, 0, 0, 0);
    chk("cyc_idx1", bus.rrggbb, 6'b101101);
    step(0, 6, 0, 0, 1, 0, 0, 0);
    chk("cyc_idx6_wrap", bus.rrggbb, 6'b110110);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    chk("cyc_idx0", bus.rrggbb, 6'b111000);
    step(0, 7, 0, 0, 1, 0, 0, 0);
    chk("cyc_idx7", bus.rrggbb, 6'b000000);
    ticks(20);
    chk("off_after24", 6'(bus.cyc_offset), 6'd0);
    ticks(3);
    step(0, 2, 0, 0, 0, 0, 0, 0);
    step(0, 2, 0, 0, 1, 0, 0, 0);
    ticks(3);
    chk("div_restart", 6'(bus.cyc_offset), 6'd0);
    ticks(1);
    chk("div_restart_step", 6'(bus.cyc_offset), 6'd1);
    ticks(8);
    chk("off_3", 6'(bus.cyc_offset), 6'd3);
    step(1, 0, 0, 1, 1, 1, 0, 6'b000111);
    chk("rst_mid_rgb", bus.rrggbb, 6'd0);
    chk("rst_mid_off", 6'(bus.cyc_offset), 6'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_over_write", bus.rrggbb, 6'b111000);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 63) == 0, 3'($urandom), $urandom_range(0, 4) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
           3'($urandom), 6'($urandom));
    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/palette_lut.md
Name: palette_lut

Overview:
- Programmable, colour-cycling palette for the VGA pixel path.
- Maps a per-pixel colour index to an RRGGBB output word through a register file.
- The register file is writable at runtime and resets to the standard 8-entry table.
- An optional colour-cycling window rotates a contiguous index range once every CYCLE_PERIOD frames.
- Sits between the pattern generator and the output pin register. Output is registered (1-cycle latency).

Parameters:
- IDX_W, 3: colour index width; DEPTH = 2**IDX_W entries.
- COLOR_W, 6: colour word width (RRGGBB for 6).
- CYC_LO, 1: first index of the cycling window.
- CYC_HI, 6: last index of the cycling window. Requires CYC_LO <= CYC_HI < DEPTH.
- CYCLE_PERIOD, 4: frame_tick pulses per rotation step. Must be ≥1.

Ports:
- clk  input  1  pixel clock
- reset  input  1  synchronous, active-high reset
- color_index  input  IDX_W  pixel colour index
- blank  input  1  1 = outside the visible area; output forced to 0
- frame_tick  input  1  one-cycle pulse per frame (vsync start)
- cycle_en  input  1  enables colour cycling
- wr_en  input  1  palette write strobe
- wr_addr  input  IDX_W  entry to write
- wr_data  input  COLOR_W  value to write
- rrggbb  output  COLOR_W  registered colour output
- cyc_offset  output  IDX_W  current rotation offset (debug)

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - Entries 0..7 load 111000, 110110, 101101, 111000, 110011, 011111, 001011, 000000.
  - When COLOR_W ≠ 6, each default is zero-extended or truncated at the LSBs.
  - Entries ≥8 load 0.
  - rrggbb=0, cyc_offset=0, frame divider=0.
  - Reset overrides a simultaneous write.
- Lookup:
  - Let N = CYC_HI-CYC_LO+1.
  - eff_idx = CYC_LO + ((color_index-CYC_LO+cyc_offset) mod N) when CYC_LO ≤ color_index ≤ CYC_HI; otherwise eff_idx = color_index.
  - On each clock: rrggbb <= blank ? 0 : pal[eff_idx].
  - Latency is exactly 1 cycle. Index, blank and offset are sampled on the same edge.
- Write:
  - When wr_en=1, pal[wr_addr] <= wr_data at the clock edge.
  - A lookup of the same entry in the same cycle returns the OLD value; the new value is visible from the next cycle. No bypass.
  - Writes address physical entries; cycling does not affect them.
- Cycling:
  - The frame divider counts frame_tick pulses while cycle_en=1.
  - When a pulse arrives with the divider at CYCLE_PERIOD-1, the divider clears to 0 and cyc_offset <= (cyc_offset+1) mod N.
  - The new offset takes effect for lookups from the next cycle.
- cycle_en=0: divider and cyc_offset both clear to 0 synchronously, returning to the identity mapping.
- N=1: cyc_offset stays 0.
- frame_tick and wr_en in the same cycle are independent; both take effect.
- blank=1 does not stall cycling or writes.
- The arithmetic mod N uses IDX_W+1-bit intermediates with no overflow; N need not be a power of 2.

Test Plan:
- Reset, then sweep color_index 0..7 with blank=0 and cycle_en=0 → one cycle later rrggbb = 111000, 110110, 101101, 111000, 110011, 011111, 001011, 000000. cyc_offset=0.
- blank=1 with color_index=1 → rrggbb=000000 next cycle. Deassert blank → 110110 the cycle after.
- Write pal[3]=010101 while color_index=3 in the same cycle → next output 111000 (old value); the following cycle gives 010101.
- Cycling with cycle_en=1, CYCLE_PERIOD=4, CYC_LO=1, CYC_HI=6:
  - Apply 4 frame_tick pulses → cyc_offset=1. index 1 → 101101 (entry 2); index 6 → 110110 (entry 1, wrap); index 0 → 111000; index 7 → 000000.
  - After 24 pulses cyc_offset returns to 0.
- After 3 ticks, drop cycle_en for one cycle, then re-enable → cyc_offset=0 and the divider restarts. The next rotation needs 4 further ticks.
- Reset asserted mid-rotation (cyc_offset=3) coincident with wr_en to entry 0 → entry 0 reads 111000, cyc_offset=0, rrggbb=0 on the reset cycle.
